// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, I/D memory freezes, branch squash, fetch drop.
// Latency: stall/bubble/flush outputs are combinational; state, drop flag and watchdog update each clock.
// Backpressure: an outstanding dmem access freezes all stages; an imem wait holds IF only.
// Optional perf counters are enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int TIMEOUT = 256
`ifdef HAZARD_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  input  logic [4:0] rd_ex,
  input  logic       ex_is_load,
  input  logic       imem_read,
  input  logic       imem_resp,
  input  logic       dmem_req,
  input  logic       dmem_resp,
  input  logic       br_taken_ex,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       bubble_ex,
  output logic       bubble_wb,
  output logic       flush_id,
  output logic       mem_timeout
`ifdef HAZARD_PERF_EN
  , output logic [CNT_W-1:0] cnt_lu
  , output logic [CNT_W-1:0] cnt_dstall
  , output logic [CNT_W-1:0] cnt_istall
  , output logic [CNT_W-1:0] cnt_flush
`endif
);

  typedef enum logic {RUN = 1'b0, DWAIT = 1'b1} state_t;

  // Counter wide enough to hold TIMEOUT itself; it parks there once reached.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  state_t        state, state_nxt;
  logic          drop_fetch, drop_nxt;
  logic [CW-1:0] wait_cnt;

  logic dstall, istall, load_use;
  // Which priority class actually drives the outputs this cycle (used by perf counters too).
  logic act_br, act_lu, act_is;

  assign dstall   = dmem_req & ~dmem_resp;
  assign istall   = imem_read & ~imem_resp;
  assign load_use = ex_is_load & (rd_ex != 5'd0) &
                    ((rs1_used_id & (rs1_id == rd_ex)) | (rs2_used_id & (rs2_id == rd_ex)));
  assign act_br   = ~dstall & br_taken_ex;
  assign act_lu   = ~dstall & ~br_taken_ex & load_use;
  assign act_is   = ~dstall & ~br_taken_ex & istall;

  // Next state, drop flag and prioritised stall/bubble/flush outputs; everything low in reset.
  always_comb begin
    state_nxt = state;
    drop_nxt  = drop_fetch;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    bubble_ex = 1'b0;
    bubble_wb = 1'b0;
    flush_id  = 1'b0;

    case (state)
      RUN:     if (dstall) state_nxt = DWAIT;
      DWAIT:   if (dmem_resp) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase

    // A new redirect with a fetch still in flight wins over clearing the old drop.
    if (act_br && istall)  drop_nxt = 1'b1;
    else if (imem_resp)    drop_nxt = 1'b0;

    if (dstall) begin
      // Whole pipe frozen; WB gets a bubble so the stalled MEM op retires once.
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      bubble_wb = 1'b1;
    end else if (act_br) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else begin
      if (act_lu) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      if (act_is) begin
        stall_if = 1'b1;
        flush_id = 1'b1;
      end
      // The killed fetch's response must not enter ID.
      if (drop_fetch) flush_id = 1'b1;
    end

    if (!rst_n) begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      stall_mem = 1'b0;
      bubble_ex = 1'b0;
      bubble_wb = 1'b0;
      flush_id  = 1'b0;
    end
  end

  // State register, drop flag and dmem watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      drop_fetch  <= 1'b0;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop_fetch <= drop_nxt;
      if (state == DWAIT && !dmem_resp) begin
        if (TIMEOUT != 0) begin
          if (wait_cnt != TO_V) wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == TO_V - 1'b1) mem_timeout <= 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating event counters, one per hazard class actually acted upon.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lu     <= '0;
      cnt_dstall <= '0;
      cnt_istall <= '0;
      cnt_flush  <= '0;
    end else begin
      if (act_lu && cnt_lu != '1)     cnt_lu     <= cnt_lu + 1'b1;
      if (dstall && cnt_dstall != '1) cnt_dstall <= cnt_dstall + 1'b1;
      if (act_is && cnt_istall != '1) cnt_istall <= cnt_istall + 1'b1;
      if (act_br && cnt_flush != '1)  cnt_flush  <= cnt_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4.
// Outputs are packed as {stall_if,stall_id,stall_ex,stall_mem,bubble_ex,bubble_wb,flush_id,mem_timeout}.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns later.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic       rs1_used_id = 0, rs2_used_id = 0, ex_is_load = 0;
  logic       imem_read = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0, br_taken_ex = 0;
  logic       stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, flush_id, mem_timeout;
`ifdef HAZARD_PERF_EN
  logic [31:0] cnt_lu, cnt_dstall, cnt_istall, cnt_flush;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_ex(rd_ex), .ex_is_load(ex_is_load),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .br_taken_ex(br_taken_ex),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .bubble_ex(bubble_ex), .bubble_wb(bubble_wb), .flush_id(flush_id), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_EN
    , .cnt_lu(cnt_lu), .cnt_dstall(cnt_dstall), .cnt_istall(cnt_istall), .cnt_flush(cnt_flush)
`endif
  );

  wire [7:0] outs = {stall_if, stall_id, stall_ex, stall_mem, bubble_ex, bubble_wb, flush_id, mem_timeout};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    rs1_id = '0; rs2_id = '0; rd_ex = '0; rs1_used_id = 0; rs2_used_id = 0; ex_is_load = 0;
    imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0; br_taken_ex = 0;
  endtask

  task automatic lu_in(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd);
    rs1_id = r1; rs1_used_id = u1; rs2_id = r2; rs2_used_id = u2; rd_ex = rd; ex_is_load = 1;
  endtask

  // Check outputs for the inputs currently applied, then advance one clock.
  task automatic tick_chk(input string tag, input logic [7:0] exp);
    #2;
    chk(tag, {24'd0, outs}, {24'd0, exp});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr_in();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset: outputs forced low even with a live dmem stall request on the inputs.
    dmem_req = 1; br_taken_ex = 1;
    #2;
    chk("reset_outs", {24'd0, outs}, 32'd0);
    @(posedge clk); #1;
    clr_in();
    rst_n = 1;
    @(posedge clk); #1;
    tick_chk("idle", 8'b0000_0000);

    // Load-use on rs1 (lw x5 ; add x6,x5,x1), exactly one cycle.
    lu_in(5'd5, 1, 5'd1, 1, 5'd5);
    tick_chk("lu_rs1", 8'b1100_1000);
    clr_in();
    tick_chk("lu_after", 8'b0000_0000);
    lu_in(5'd3, 1, 5'd9, 1, 5'd9);
    tick_chk("lu_rs2", 8'b1100_1000);
    lu_in(5'd9, 0, 5'd2, 1, 5'd9);
    tick_chk("lu_unused", 8'b0000_0000);
    lu_in(5'd0, 1, 5'd0, 1, 5'd0);
    tick_chk("lu_x0", 8'b0000_0000);
    clr_in();

    // dmem stall for 3 cycles, with a branch and load-use also present to prove priority.
    dmem_req = 1;
    tick_chk("dstall_0", 8'b1111_0100);
    br_taken_ex = 1;
    tick_chk("dstall_br", 8'b1111_0100);
    br_taken_ex = 0; lu_in(5'd5, 1, 5'd0, 0, 5'd5);
    tick_chk("dstall_lu", 8'b1111_0100);
    clr_in(); dmem_req = 1; dmem_resp = 1;
    tick_chk("dstall_resp", 8'b0000_0000);
    clr_in();
    tick_chk("dstall_done", 8'b0000_0000);

    // Taken branch with a fetch in flight: the late fetch is dropped.
    br_taken_ex = 1; imem_read = 1;
    tick_chk("br_flush", 8'b0000_1010);
    br_taken_ex = 0;
    tick_chk("drop_istall", 8'b1000_0010);
    imem_resp = 1;
    tick_chk("drop_resp", 8'b0000_0010);
    imem_read = 0; imem_resp = 0;
    tick_chk("drop_clear", 8'b0000_0000);
    // Branch with no fetch pending does not set the drop flag.
    br_taken_ex = 1;
    tick_chk("br_only", 8'b0000_1010);
    br_taken_ex = 0;
    tick_chk("br_only_after", 8'b0000_0000);

    // imem stall alone, then coinciding with load-use (union).
    imem_read = 1;
    tick_chk("istall", 8'b1000_0010);
    lu_in(5'd7, 1, 5'd0, 0, 5'd7);
    tick_chk("istall_lu", 8'b1100_1010);
    clr_in();

    // Watchdog: one RUN cycle then 4 DWAIT cycles before mem_timeout shows.
    dmem_req = 1;
    for (int i = 0; i < 5; i++) tick_chk($sformatf("wd_wait%0d", i), 8'b1111_0100);
    tick_chk("wd_set", 8'b1111_0101);
    dmem_resp = 1;
    tick_chk("wd_resp", 8'b0000_0001);
    clr_in();
    tick_chk("wd_sticky", 8'b0000_0001);

    // Reset while waiting on dmem: immediate return, watchdog cleared.
    dmem_req = 1;
    tick_chk("rst_mid_0", 8'b1111_0101);
    tick_chk("rst_mid_1", 8'b1111_0101);
    rst_n = 0;
    #1;
    chk("rst_async", {24'd0, outs}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1; clr_in();
    tick_chk("rst_mid_clear", 8'b0000_0000);
    dmem_req = 1;
    tick_chk("rst_mid_run", 8'b1111_0100);
    clr_in();
    tick_chk("rst_mid_idle", 8'b0000_0000);

`ifdef HAZARD_PERF_EN
    do_reset();
    chk("cnt_lu_rst", cnt_lu, 32'd0);
    lu_in(5'd5, 1, 5'd0, 0, 5'd5);
    tick_chk("perf_lu0", 8'b1100_1000);
    tick_chk("perf_lu1", 8'b1100_1000);
    clr_in(); dmem_req = 1;
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1; dmem_resp = 1;
    @(posedge clk); #1; clr_in();
    #2;
    chk("cnt_lu", cnt_lu, 32'd2);
    chk("cnt_dstall", cnt_dstall, 32'd5);
    chk("cnt_istall", cnt_istall, 32'd0);
    chk("cnt_flush", cnt_flush, 32'd0);
    rst_n = 0;
    #1;
    chk("cnt_rst", cnt_lu | cnt_dstall | cnt_istall | cnt_flush, 32'd0);
    rst_n = 1;
`endif

    do_reset();
    tick_chk("final_idle", 8'b0000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule
